// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the bit-serial adder.
//   start, a, b, cin : request and operands, driven by the master
//   busy, done       : progress and one-cycle completion pulse, driven by the slave
//   sum, cout        : registered result, driven by the slave
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands LSB first, one bit per clock, through a single
// 1-bit full-adder cell and a registered carry.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all state
//   bus   : slave side of serial_adder_if (start/a/b/cin in; busy/done/sum/cout out)
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             fa_s, fa_c;
  logic [WIDTH-1:0] acc_sh;
  logic             load;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    load    = 1'b0;

    // Full-adder cell on the current LSBs and the registered carry.
    fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at acc[0].
    acc_sh            = acc_q >> 1;
    acc_sh[WIDTH-1]   = fa_s;

    unique case (state_q)
      StIdle: load = bus.start;
      StRun: begin
        acc_d   = acc_sh;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          sum_d   = acc_sh;
          cout_d  = fa_c;
          state_d = StDone;
        end
      end
      StDone: begin
        load    = bus.start;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      a_sh_d  = bus.a;
      b_sh_d  = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
      acc_d   = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Stimulus helpers: called 1 time unit after a rising edge; return 1 unit after the next.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
  endtask

  task automatic drive1(input logic a, input logic b, input logic cin);
    bus1.start = 1'b1;
    bus1.a     = a;
    bus1.b     = b;
    bus1.cin   = cin;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
  endtask

  // Counts cycles with busy high, bounded; leaves the bench in the first non-busy cycle.
  task automatic wait8(output int n);
    n = 0;
    while (bus8.busy === 1'b1 && n < 64) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait1(output int n);
    n = 0;
    while (bus1.busy === 1'b1 && n < 64) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (bus8.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy8 got %b want 0", bus8.busy); end
    n_cmp++; if (bus8.done !== 1'b0) begin n_err++; $display("FAIL reset_done8 got %b want 0", bus8.done); end
    n_cmp++; if (bus8.sum !== 8'd0) begin n_err++; $display("FAIL reset_sum8 got %0d want 0", bus8.sum); end
    n_cmp++; if (bus8.cout !== 1'b0) begin n_err++; $display("FAIL reset_cout8 got %b want 0", bus8.cout); end
    n_cmp++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy1 got %b want 0", bus1.busy); end
    n_cmp++; if (bus1.done !== 1'b0) begin n_err++; $display("FAIL reset_done1 got %b want 0", bus1.done); end
    n_cmp++; if (bus1.sum !== 1'b0) begin n_err++; $display("FAIL reset_sum1 got %b want 0", bus1.sum); end
    n_cmp++; if (bus1.cout !== 1'b0) begin n_err++; $display("FAIL reset_cout1 got %b want 0", bus1.cout); end
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int n;
    drive8(8'd100, 8'd27, 1'b0);
    wait8(n);
    n_cmp++; if (n != 8) begin n_err++; $display("FAIL basic_busy_cycles got %0d want 8", n); end
    n_cmp++; if (bus8.done !== 1'b1) begin n_err++; $display("FAIL basic_done got %b want 1", bus8.done); end
    n_cmp++; if (bus8.sum !== 8'd127) begin n_err++; $display("FAIL basic_sum got %0d want 127", bus8.sum); end
    n_cmp++; if (bus8.cout !== 1'b0) begin n_err++; $display("FAIL basic_cout got %b want 0", bus8.cout); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus8.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b want 0", bus8.done); end
    n_cmp++; if (bus8.sum !== 8'd127) begin n_err++; $display("FAIL basic_sum_hold got %0d want 127", bus8.sum); end
  endtask

  task automatic test_wrap();
    int n;
    drive8(8'd255, 8'd1, 1'b0);
    wait8(n);
    n_cmp++; if (bus8.done !== 1'b1) begin n_err++; $display("FAIL wrap1_done got %b want 1", bus8.done); end
    n_cmp++; if (bus8.sum !== 8'd0) begin n_err++; $display("FAIL wrap1_sum got %0d want 0", bus8.sum); end
    n_cmp++; if (bus8.cout !== 1'b1) begin n_err++; $display("FAIL wrap1_cout got %b want 1", bus8.cout); end
    @(posedge clk);
    #1;
    drive8(8'd255, 8'd255, 1'b1);
    wait8(n);
    n_cmp++; if (bus8.done !== 1'b1) begin n_err++; $display("FAIL wrap2_done got %b want 1", bus8.done); end
    n_cmp++; if (bus8.sum !== 8'd255) begin n_err++; $display("FAIL wrap2_sum got %0d want 255", bus8.sum); end
    n_cmp++; if (bus8.cout !== 1'b1) begin n_err++; $display("FAIL wrap2_cout got %b want 1", bus8.cout); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_ignored();
    int n;
    bit seen;
    drive8(8'd3, 8'd4, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    // Third cycle of RUN: a new request here must be dropped.
    bus8.start = 1'b1;
    bus8.a     = 8'd200;
    bus8.b     = 8'd200;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    wait8(n);
    n_cmp++; if (n != 5) begin n_err++; $display("FAIL ignored_busy_rest got %0d want 5", n); end
    n_cmp++; if (bus8.done !== 1'b1) begin n_err++; $display("FAIL ignored_done got %b want 1", bus8.done); end
    n_cmp++; if (bus8.sum !== 8'd7) begin n_err++; $display("FAIL ignored_sum got %0d want 7", bus8.sum); end
    n_cmp++; if (bus8.cout !== 1'b0) begin n_err++; $display("FAIL ignored_cout got %b want 0", bus8.cout); end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL ignored_no_second_op got %b want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int n;
    bus8.start = 1'b1;
    bus8.a     = 8'd10;
    bus8.b     = 8'd20;
    bus8.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus8.a = 8'd1;
    bus8.b = 8'd2;
    wait8(n);
    n_cmp++; if (n != 8) begin n_err++; $display("FAIL b2b_first_busy got %0d want 8", n); end
    n_cmp++; if (bus8.done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got %b want 1", bus8.done); end
    n_cmp++; if (bus8.sum !== 8'd30) begin n_err++; $display("FAIL b2b_first_sum got %0d want 30", bus8.sum); end
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    n_cmp++; if (bus8.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_in_done got %b want 1", bus8.busy); end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_cmp++; if (bus8.sum !== 8'd30) begin n_err++; $display("FAIL b2b_sum_hold_run got %0d want 30", bus8.sum); end
    wait8(n);
    // 1 cycle from first done to accept, then 3 + n more busy cycles: 9 in total.
    n_cmp++; if (n + 4 != 9) begin n_err++; $display("FAIL b2b_spacing got %0d want 9", n + 4); end
    n_cmp++; if (bus8.done !== 1'b1) begin n_err++; $display("FAIL b2b_second_done got %b want 1", bus8.done); end
    n_cmp++; if (bus8.sum !== 8'd3) begin n_err++; $display("FAIL b2b_second_sum got %0d want 3", bus8.sum); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit seen;
    drive8(8'd50, 8'd60, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus8.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", bus8.busy); end
    n_cmp++; if (bus8.done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b want 0", bus8.done); end
    n_cmp++; if (bus8.sum !== 8'd0) begin n_err++; $display("FAIL midrst_sum got %0d want 0", bus8.sum); end
    n_cmp++; if (bus8.cout !== 1'b0) begin n_err++; $display("FAIL midrst_cout got %b want 0", bus8.cout); end
    @(posedge clk);
    #4 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_done got %b want 0", seen); end
    drive8(8'd1, 8'd1, 1'b0);
    wait8(n);
    n_cmp++; if (bus8.done !== 1'b1) begin n_err++; $display("FAIL midrst_fresh_done got %b want 1", bus8.done); end
    n_cmp++; if (bus8.sum !== 8'd2) begin n_err++; $display("FAIL midrst_fresh_sum got %0d want 2", bus8.sum); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_width1();
    int n;
    logic [7:0] tt_sum;
    logic [7:0] tt_cout;
    logic [2:0] v;
    tt_sum  = 8'b1001_0110;  // indexed by {a, b, cin}
    tt_cout = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive1(v[2], v[1], v[0]);
      wait1(n);
      n_cmp++; if (n != 1) begin n_err++; $display("FAIL w1_busy_%0d got %0d want 1", i, n); end
      n_cmp++; if (bus1.done !== 1'b1) begin n_err++; $display("FAIL w1_done_%0d got %b want 1", i, bus1.done); end
      n_cmp++; if (bus1.sum !== tt_sum[i]) begin n_err++; $display("FAIL w1_sum_%0d got %b want %b", i, bus1.sum, tt_sum[i]); end
      n_cmp++; if (bus1.cout !== tt_cout[i]) begin n_err++; $display("FAIL w1_cout_%0d got %b want %b", i, bus1.cout, tt_cout[i]); end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.cin   = 1'b0;
    bus1.start = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    bus1.cin   = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that adds two WIDTH-bit operands one bit per clock, LSB first, through a single 1-bit full-adder cell and a registered carry. It is the sequential stage wrapped directly around the team's 1-bit full-adder cell. It feeds that cell one (a, b, carry-in) triple per cycle and consumes its (carry, sum) outputs. The block trades latency for area. Results are presented with a one-cycle done pulse to the downstream consumer.

## Interface
- WIDTH, 8, operand and sum width in bits (legal range 1–32)
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  reset, asynchronous and active-low; clears all state
- start  input  1  request to begin an addition; sampled on rising clk
- a  input  WIDTH  operand A, sampled only on the accepting edge
- b  input  WIDTH  operand B, sampled only on the accepting edge
- cin  input  1  carry-in for bit 0, sampled only on the accepting edge
- busy  output  1  high while an addition is in progress (state RUN)
- done  output  1  one-cycle pulse marking valid sum/cout (state DONE)
- sum  output  WIDTH  registered result, a + b + cin modulo 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: if start=1, load a_sh←a, b_sh←b, carry←cin, cnt←0, acc←0, and go to RUN. Otherwise stay in IDLE.
- RUN, each cycle:
  - The full-adder cell takes (a_sh[0], b_sh[0], carry) and produces (c, s).
  - acc shifts right with s inserted at the MSB.
  - a_sh and b_sh shift right with zero fill.
  - carry←c and cnt←cnt+1.
- RUN ends on the cycle where cnt = WIDTH-1. On that edge:
  - sum←final acc value, including the last s at the MSB.
  - cout←c.
  - State goes to DONE.
- DONE: done=1 for exactly this cycle. If start=1 in this cycle, accept a new operation exactly as in IDLE and go to RUN. Otherwise go to IDLE.
- start is ignored while in RUN. Operand inputs may change freely after the accepting edge.
- sum and cout change only on the completion edge. They hold their value through IDLE and through the entire next RUN until the next completion.
- cnt is $clog2(WIDTH+1) bits wide. Arithmetic is unsigned and any carry beyond cout is discarded.
- WIDTH=1: RUN lasts exactly one cycle, and sum = a ^ b ^ cin.

## Timing
- Reset values (asserted asynchronously, independent of clk):
  - busy=0, done=0, sum=0, cout=0
  - carry=0, cnt=0, state IDLE
- Reset deassertion is synchronous to the design. The first edge after rst_n rises may accept start.
- Latency:
  - start sampled high at edge k.
  - busy is high from after edge k until edge k+WIDTH.
  - sum/cout update at edge k+WIDTH.
  - done is high for the cycle between edges k+WIDTH and k+WIDTH+1.
- Throughput: back-to-back operations every WIDTH+1 cycles, when start is held high or reasserted in DONE.
- Reset mid-RUN: the operation is aborted and no done pulse is produced. sum/cout return to 0.
- done and busy are never high in the same cycle.

## Test plan
- Basic add: WIDTH=8, a=100, b=27, cin=0, pulse start. Required: busy high for 8 cycles, then done for 1 cycle, with sum=127 and cout=0.
- Wrap and carry: a=255, b=1, cin=0 gives sum=0, cout=1. Then a=255, b=255, cin=1 gives sum=255, cout=1.
- Start ignored during RUN: start a=3, b=4, then pulse start with a=200, b=200 during cycle 3 of RUN. Required: done once with sum=7, cout=0, and no second operation begins.
- Back-to-back: hold start=1 with a=10, b=20, then change to a=1, b=2 before the first done. Required: first done shows sum=30; the second operation is accepted on the done cycle and its done arrives 9 cycles later with sum=3.
- Reset mid-operation: start a=50, b=60, then drop rst_n during cycle 4 of RUN. Required: busy=0, done=0, sum=0, cout=0 immediately. No done pulse follows. A fresh operation with a=1, b=1 then yields sum=2.
- Exhaustive WIDTH=1 instance: all 8 combinations of a, b, cin. Required: sum/cout match the full-adder truth table, and every operation has 1 cycle of busy followed by done.
